cpu_rx_handshake: RTL and testbench
===================================

// Module: cpu_rx_handshake
// PURPOSE
//  CPU-side receiver for the peripheral->CPU return path of the 4-phase send/ack protocol.
//  Peripheral raises send with data stable; this block captures the word, raises ack,
//  waits for send to fall, drops ack. Captured words go into a small FIFO (first-word-
//  fall-through) drained by the CPU. Sits beside the CPU transmit FSM; mirrors its handshake.
// PARAMETERS
//  WIDTH  4  data word width (bits)
//  DEPTH  4  FIFO depth in words; power of 2, >=2
// PORTS
//  clk       in   1                 clock, all logic on posedge
//  rst       in   1                 reset, asynchronous, active-high
//  send      in   1                 request from peripheral, synchronous to clk
//  dados     in   WIDTH             data from peripheral; stable while send=1
//  ack       out  1                 acknowledge to peripheral (registered)
//  estado    out  2                 current FSM state code (debug)
//  rd_en     in   1                 CPU pop; ignored when empty=1
//  rd_data   out  WIDTH             head of FIFO; valid only when empty=0
//  empty     out  1                 FIFO holds 0 words
//  full      out  1                 FIFO holds DEPTH words
//  count     out  $clog2(DEPTH)+1   words held
// BEHAVIOUR
//  Reset (async): state IDLE, ack=0, estado=0, pointers=0, count=0, empty=1, full=0;
//   FIFO contents not cleared, rd_data don't-care while empty.
//  FSM (estado code):
//   IDLE 00: ack=0. send=1 & full=0 -> CAP; else stay (full = backpressure, ack withheld).
//   CAP  01: ack=0. On the edge leaving CAP, dados written at wr_ptr -> ACK.
//   ACK  10: ack=1. Stay while send=1 (no further writes); send=0 -> DONE.
//   DONE 11: ack=0. Unconditionally -> IDLE (one-cycle guard against stale send).
//  Latency: send sampled 1 at edge E0 -> CAP; at E1 word written, ack=1, empty=0, count+1.
//   ack falls at the edge after send is sampled 0; minimum transfer = 4 cycles.
//  FIFO: wr_ptr/rd_ptr $clog2(DEPTH) bits, wrap modulo DEPTH; count saturates by design
//   (never written when full since IDLE checks full before CAP).
//  rd_en & !empty: rd_ptr+1, count-1 at the edge; rd_data shows next word after the edge.
//  Simultaneous write (CAP edge) and pop: both occur, count unchanged, full/empty unchanged.
//  Pop while full in IDLE with send=1: IDLE sees full=1 this cycle, enters CAP next cycle.
//  rd_en while empty: no pointer/count change.
//  Reset mid-transfer: ack drops immediately; if send still 1 after release, it is a new
//   transfer and is captured again (peripheral owns duplicate suppression).
//  full/empty/count registered, derived from count.
// CONFIGURATION
//  RX_PARITY_EN defined: extra ports paridade (in,1) and erro (out,1, reset 0).
//   Even parity over {paridade,dados} checked in CAP; mismatch -> word NOT written,
//   handshake still completes (ack issued), erro set sticky until rst.
//  RX_PARITY_EN undefined: ports paridade/erro absent; every captured word is written.
// TESTING
//  1 rst, send=1 dados=4'hA -> ack=1 two edges later, empty=0, rd_data=4'hA, count=1.
//  2 write 1,2,3,4 no reads -> full=1,count=4; send with 4'h5 -> ack stays 0, estado=00;
//    one rd_en -> rd_data=2, count=3; transfer of 5 then completes, count=4.
//  3 rd_en pulse on the CAP edge with count=2 -> count stays 2, order preserved.
//  4 send held 10 cycles after ack -> ack held 1, count +1 only; send=0 -> ack=0 next
//    edge, estado 11 then 00.
//  5 rst asserted in ACK with count=3 -> ack=0, count=0, empty=1 same cycle, no clock.
//  6 RX_PARITY_EN: dados=4'b0001 paridade=0 -> ack completes, count unchanged, erro=1;
//    next dados=4'b0011 paridade=0 -> written, erro stays 1.

Source files
------------

// File: rtl/cpu_rx_handshake.sv
// CPU-side receiver for the 4-phase send/ack return path, feeding a first-word-fall-through FIFO.
// Optional even-parity check on captured words is enabled by defining RX_PARITY_EN.
module cpu_rx_handshake #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     send,
    input  logic [WIDTH-1:0]         dados,
`ifdef RX_PARITY_EN
    input  logic                     paridade,
    output logic                     erro,
`endif
    output logic                     ack,
    output logic [1:0]               estado,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CAP  = 2'b01,
        S_ACK  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             r_state;
    logic               r_ack;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_empty;
    logic               r_full;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_par_ok;
    logic               w_wr;
    logic               w_rd;
    logic [CW-1:0]      w_count_next;

`ifdef RX_PARITY_EN
    logic               r_erro;
    assign w_par_ok = ~^{paridade, dados};
    assign erro     = r_erro;
`else
    assign w_par_ok = 1'b1;
`endif

    // A word enters the FIFO only on the edge that leaves CAP.
    assign w_wr = (r_state == S_CAP) && w_par_ok;
    assign w_rd = rd_en && !r_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_rd)
            w_count_next = r_count + CW'(1);
        else if (!w_wr && w_rd)
            w_count_next = r_count - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    // Full holds the peripheral off: ack is withheld until a pop frees space.
                    if (send && !r_full)
                        r_state <= S_CAP;
                end
                S_CAP: begin
                    r_ack   <= 1'b1;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (!send) begin
                        r_ack   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == CW'(DEPTH));
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_erro <= 1'b0;
        else if (r_state == S_CAP && !w_par_ok)
            r_erro <= 1'b1;
    end
`endif

    // Storage is deliberately left out of reset; rd_data is meaningless while empty.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= dados;
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign ack     = r_ack;
    assign estado  = r_state;
    assign empty   = r_empty;
    assign full    = r_full;
    assign count   = r_count;

endmodule

// File: tb/tb_cpu_rx_handshake.sv
// Directed and randomized bench for cpu_rx_handshake; a queue models FIFO contents.
// Parity scenarios run only when RX_PARITY_EN is defined for both bench and design.
module tb_cpu_rx_handshake;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             send = 1'b0;
    logic [WIDTH-1:0] dados = '0;
    logic             ack;
    logic [1:0]       estado;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [2:0]       count;
`ifdef RX_PARITY_EN
    logic             paridade = 1'b0;
    logic             erro;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] model_q[$];

    cpu_rx_handshake #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .send(send),
        .dados(dados),
`ifdef RX_PARITY_EN
        .paridade(paridade),
        .erro(erro),
`endif
        .ack(ack),
        .estado(estado),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
        .full(full),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
        if (model_q.size() != 0)
            chk({tag, "_head"}, 32'(rd_data), 32'(model_q[0]));
    endtask

    // Full handshake; the FIFO must have room, so ack is due exactly two edges after send rises.
    task automatic transfer(input logic [WIDTH-1:0] d, input logic store);
        int n;
        send  = 1'b1;
        dados = d;
`ifdef RX_PARITY_EN
        paridade = store ? ^d : ~^d;
`endif
        n = 0;
        while (ack !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("ack_latency", 32'(n), 32'd2);
        if (store)
            model_q.push_back(d);
        chk_fifo("after_capture");
        send = 1'b0;
        tick();
        chk("ack_fall", 32'(ack), 32'd0);
        chk("estado_done", 32'(estado), 32'd3);
        tick();
        chk("estado_idle", 32'(estado), 32'd0);
    endtask

    task automatic pop();
        if (model_q.size() != 0)
            chk("pop_head", 32'(rd_data), 32'(model_q[0]));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (model_q.size() != 0)
            void'(model_q.pop_front());
        chk_fifo("after_pop");
    endtask

    initial begin
        // Test 1: reset state, then a single transfer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_estado", 32'(estado), 32'd0);
        chk_fifo("rst");
        send = 1'b1;
        dados = 4'hA;
`ifdef RX_PARITY_EN
        paridade = ^dados;
`endif
        tick();
        chk("t1_cap_ack", 32'(ack), 32'd0);
        chk("t1_cap_estado", 32'(estado), 32'd1);
        tick();
        chk("t1_ack", 32'(ack), 32'd1);
        model_q.push_back(4'hA);
        chk_fifo("t1");
        send = 1'b0;
        tick();
        tick();
        pop();

        // Test 2: fill, backpressure, pop releases the pending transfer
        for (int i = 1; i <= 4; i++)
            transfer(WIDTH'(i), 1'b1);
        chk_fifo("t2_full");
        send = 1'b1;
        dados = 4'h5;
`ifdef RX_PARITY_EN
        paridade = ^dados;
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_held_ack", 32'(ack), 32'd0);
            chk("t2_held_estado", 32'(estado), 32'd0);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(model_q.pop_front());
        chk_fifo("t2_pop");
        chk("t2_still_idle", 32'(estado), 32'd0);
        tick();
        chk("t2_cap", 32'(estado), 32'd1);
        tick();
        chk("t2_ack", 32'(ack), 32'd1);
        model_q.push_back(4'h5);
        chk_fifo("t2_refill");
        send = 1'b0;
        tick();
        tick();
        while (model_q.size() != 0)
            pop();

        // Test 3: pop on the capture edge
        transfer(4'h7, 1'b1);
        transfer(4'h8, 1'b1);
        send = 1'b1;
        dados = 4'h9;
`ifdef RX_PARITY_EN
        paridade = ^dados;
`endif
        tick();
        chk("t3_cap", 32'(estado), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(4'h9);
        chk("t3_ack", 32'(ack), 32'd1);
        chk_fifo("t3_simul");
        send = 1'b0;
        tick();
        tick();
        while (model_q.size() != 0)
            pop();

        // Test 4: send held long after ack
        send = 1'b1;
        dados = 4'h6;
`ifdef RX_PARITY_EN
        paridade = ^dados;
`endif
        tick();
        tick();
        model_q.push_back(4'h6);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_ack", 32'(ack), 32'd1);
            chk("t4_hold_count", 32'(count), 32'd1);
        end
        send = 1'b0;
        tick();
        chk("t4_ack_fall", 32'(ack), 32'd0);
        chk("t4_done", 32'(estado), 32'd3);
        tick();
        chk("t4_idle", 32'(estado), 32'd0);
        pop();

        // Test 5: asynchronous reset while in ACK with count=3
        transfer(4'h1, 1'b1);
        transfer(4'h2, 1'b1);
        send = 1'b1;
        dados = 4'h3;
`ifdef RX_PARITY_EN
        paridade = ^dados;
`endif
        tick();
        tick();
        chk("t5_in_ack", 32'(ack), 32'd1);
        chk("t5_count3", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        chk("t5_rst_ack", 32'(ack), 32'd0);
        chk("t5_rst_estado", 32'(estado), 32'd0);
        chk_fifo("t5_rst");
        #1;
        rst = 1'b0;
        tick();
        tick();
        chk("t5_recapture_ack", 32'(ack), 32'd1);
        model_q.push_back(4'h3);
        chk_fifo("t5_recapture");
        send = 1'b0;
        tick();
        tick();
        pop();

`ifdef RX_PARITY_EN
        // Test 6: parity error drops the word, flag is sticky
        chk("t6_erro_clear", 32'(erro), 32'd0);
        transfer(4'b0001, 1'b0);
        chk("t6_erro_set", 32'(erro), 32'd1);
        send = 1'b1;
        dados = 4'b0011;
        paridade = 1'b0;
        tick();
        tick();
        model_q.push_back(4'b0011);
        chk_fifo("t6_good");
        send = 1'b0;
        tick();
        tick();
        chk("t6_erro_sticky", 32'(erro), 32'd1);
        pop();
`endif

        // Randomized mix of transfers and pops against the queue model
        for (int i = 0; i < 60; i++) begin
            if (($urandom_range(0, 2) == 0 && model_q.size() != 0) || model_q.size() == DEPTH)
                pop();
            else
                transfer(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'b1);
        end
        // A pop on an empty FIFO must leave everything untouched
        while (model_q.size() != 0)
            pop();
        pop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
